// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types and constants for the instruction-fetch front end.
//   - WORD_W, INSTR_BYTES, NOP_INSTR : datapath word width, PC step, empty-slot word
//   - fetch_state_t                  : RUN / FAULT fetch states
//   - fetch_entry_t                  : one buffered {pc, instr} pair
//   - fetch_addr_bad()               : misaligned or out-of-ROM address test
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int                WORD_W      = 32;
    localparam int                INSTR_BYTES = 4;
    localparam logic [WORD_W-1:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // A fetch address is unusable if it is not word aligned or lies at or
    // beyond the end of the ROM.
    function automatic logic fetch_addr_bad(input logic [WORD_W-1:0] addr,
                                            input logic [WORD_W-1:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO of fetch_entry_t used as the fetch -> decode buffer.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     push        write wr_entry (accepted when not full, or full with pop)
//     pop         drop the head entry (ignored when empty)
//     flush       discard all entries; wins over push and pop
//     wr_entry    entry written on push
//     full/empty  occupancy flags
//     count       number of valid entries (0..DEPTH)
//     head        oldest entry, all-zero when empty
//   Pointers carry one extra MSB so full and empty are distinguished
//   without a separate occupancy register.
// ---------------------------------------------------------------------------
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Push into a full FIFO is only legal when the head leaves in the same
    // cycle; the slot being freed is the one being written.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Zeroed when empty so decode never sees stale words on the bus.
    always_comb begin
        head = '{pc: '0, instr: NOP_INSTR};
        if (!empty) head = mem_q[rd_ptr_q[AW-1:0]];
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch initiator between the instruction ROM and decode.
//   Owns the fetch PC (fpc), drives the ROM address, buffers {pc, instr}
//   pairs in fetch_fifo and presents them to decode over valid/ready.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     imem_address        ROM byte address, always the fetch PC register
//     imem_instruction    ROM word for imem_address, same cycle
//     redirect_valid/pc   branch/jump: flush buffer, restart at redirect_pc
//     out_valid/ready     handshake to decode
//     out_pc/out_instr    head pair, zero when out_valid=0
//     fault/fault_pc      fetch halted on a bad address, and that address
//     dbg_state           current fetch state
//     dbg_count           current buffer occupancy
//
//   Handshake: a pair transfers on a rising edge where out_valid and
//   out_ready are both 1. While out_valid=1 the head pair stays unchanged
//   until it transfers; out_valid never drops without a transfer except on
//   a redirect (flush) or reset.
//
//   Per-edge priority: redirect, then out-of-range fpc, then normal
//   pop/push. A redirect discards the pop of that edge too, since the head
//   it would have delivered belongs to the abandoned path.
// ---------------------------------------------------------------------------
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [WORD_W-1:0] IMEM_SIZE  = 32'h0000_0800,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WORD_W-1:0]           imem_address,
    input  logic [WORD_W-1:0]           imem_instruction,
    input  logic                        redirect_valid,
    input  logic [WORD_W-1:0]           redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_pc,
    output logic [WORD_W-1:0]           out_instr,
    output logic                        fault,
    output logic [WORD_W-1:0]           fault_pc,
    output fetch_state_t                dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] fpc_q, fpc_d;
    logic [WORD_W-1:0] fault_pc_q, fault_pc_d;
    logic              fault_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_wr_entry;

    logic              redirect_bad;
    logic              fpc_out_of_range;

    assign redirect_bad     = fetch_addr_bad(redirect_pc, IMEM_SIZE);
    assign fpc_out_of_range = (fpc_q >= IMEM_SIZE);

    assign fifo_wr_entry = '{pc: fpc_q, instr: imem_instruction};

    // Next-state and buffer strobes for one edge.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        fault_pc_d = fault_pc_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            if (redirect_bad) begin
                // fpc stays where it was; nothing is fetched while faulted.
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
            end else begin
                state_d    = RUN;
                fpc_d      = redirect_pc;
                fault_pc_d = '0;
            end
        end else begin
            // Buffered entries drain in either state.
            fifo_pop = ~fifo_empty & out_ready;
            if (state_q == RUN) begin
                if (fpc_out_of_range) begin
                    state_d    = FAULT;
                    fault_pc_d = fpc_q;
                end else if (~fifo_full | fifo_pop) begin
                    fifo_push = 1'b1;
                    fpc_d     = fpc_q + WORD_W'(INSTR_BYTES);
                end
            end
        end
    end

    // Fetch state machine with registered fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fpc_q      <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            fault_q    <= (state_d == FAULT);
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .wr_entry (fifo_wr_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (dbg_count),
        .head     (fifo_head)
    );

    assign imem_address = fpc_q;
    assign out_valid    = ~fifo_empty;
    assign out_pc       = fifo_head.pc;
    assign out_instr    = fifo_head.instr;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign dbg_state    = state_q;

    a_no_push_in_fault : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == FAULT) |-> !fifo_push);

    a_no_push_on_flush : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_flush |-> !fifo_push);

endmodule
